// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
//   N        : number of requesters (fixed at 8, matches the 8-to-3 encoder)
//   PTR_W    : width of a requester index
//   arb_state_t : arbiter FSM states
//   onehot8  : index -> one-hot grant vector
package rr_arb_pkg;

    localparam int N     = 8;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N-1:0] onehot8(input logic [PTR_W-1:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_chk.sv
// Property checker for rr_arbiter8 outputs.
//   clk, rst_n  : same clock/reset as the arbiter
//   grant       : arbiter grant bus
//   grant_valid : arbiter grant-valid flag
module rr_arbiter8_chk
    import rr_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] grant,
    input  logic         grant_valid
);

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
        grant_valid == (|grant));

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker.
// Returns the first set bit of m when scanning s, s+1, ..., 7, 0, ..., s-1.
//   m     : candidate mask
//   s     : scan start position
//   idx   : index of the first set bit found
//   found : 1 when m has any bit set
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]     m,
    input  logic [PTR_W-1:0] s,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    logic [PTR_W-1:0] pos_s;

    // Scan from the far end back towards s so the last hit is the nearest one.
    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        pos_s = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            pos_s = s + 3'(k);
            if (m[pos_s]) begin
                found = 1'b1;
                idx   = pos_s;
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with grant locking and a hold-time limit.
// The grant bus feeds an 8-to-3 one-hot encoder, so it is always one-hot or zero.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   req         : level-sensitive request lines, bit i = requester i
//   grant       : registered one-hot grant, zero when idle
//   grant_valid : registered OR of grant
//   timeout     : registered 1-cycle pulse when the owner was rotated by MAX_HOLD
// MAX_HOLD: max consecutive cycles per owner (1..255), 0 disables the limit.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);

    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_r, state_nx_s;
    logic [PTR_W-1:0]  ptr_r, ptr_nx_s;
    logic [PTR_W-1:0]  owner_r, owner_nx_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_nx_s;
    logic [N-1:0]      grant_r, grant_nx_s;
    logic              grant_valid_r;
    logic              timeout_r, timeout_nx_s;

    logic [PTR_W-1:0]  pick_start_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic              pick_found_s;
    logic              owner_req_s;
    logic              expire_s;
    logic              release_s;

    // Single picker: IDLE searches from ptr, GRANT searches from just past the owner.
    always_comb begin
        pick_start_s = ptr_r;
        if (state_r == GRANT) begin
            pick_start_s = owner_r + 3'd1;
        end else begin
            pick_start_s = ptr_r;
        end
    end

    rr_pick8 u_pick (
        .m     (req),
        .s     (pick_start_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Release conditions for the current owner.
    always_comb begin
        owner_req_s = req[owner_r];
        expire_s    = 1'b0;
        if ((MAX_HOLD != 0) && owner_req_s && (hold_cnt_r == HOLD_LAST)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
        release_s = !owner_req_s || expire_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        owner_nx_s   = owner_r;
        hold_nx_s    = hold_cnt_r;
        grant_nx_s   = grant_r;
        timeout_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nx_s = GRANT;
                    owner_nx_s = pick_idx_s;
                    grant_nx_s = onehot8(pick_idx_s);
                    hold_nx_s  = '0;
                end else begin
                    state_nx_s = IDLE;
                    grant_nx_s = 8'h00;
                end
            end
            GRANT: begin
                if (release_s) begin
                    // An expiring owner is still in req, but the scan starts past it,
                    // so it can only win when nobody else is asking.
                    ptr_nx_s     = owner_r + 3'd1;
                    timeout_nx_s = expire_s;
                    hold_nx_s    = '0;
                    if (pick_found_s) begin
                        state_nx_s = GRANT;
                        owner_nx_s = pick_idx_s;
                        grant_nx_s = onehot8(pick_idx_s);
                    end else begin
                        state_nx_s = IDLE;
                        grant_nx_s = 8'h00;
                    end
                end else begin
                    hold_nx_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                grant_nx_s = 8'h00;
                hold_nx_s  = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ptr_r         <= 3'd0;
            owner_r       <= 3'd0;
            hold_cnt_r    <= '0;
            grant_r       <= 8'h00;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            ptr_r         <= ptr_nx_s;
            owner_r       <= owner_nx_s;
            hold_cnt_r    <= hold_nx_s;
            grant_r       <= grant_nx_s;
            grant_valid_r <= |grant_nx_s;
            timeout_r     <= timeout_nx_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] g   [3];
    logic       gv  [3];
    logic       to  [3];

    int total = 0;
    int bad   = 0;

    // Three instances: MAX_HOLD = 15, 4, 0 (index 0, 1, 2)
    rr_arbiter8 #(.MAX_HOLD(15)) dut15 (.clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[0]), .grant_valid(gv[0]), .timeout(to[0]));
    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[1]), .grant_valid(gv[1]), .timeout(to[1]));
    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[2]), .grant_valid(gv[2]), .timeout(to[2]));

    rr_arbiter8_chk chk15 (.clk(clk), .rst_n(rst_n), .grant(g[0]), .grant_valid(gv[0]));
    rr_arbiter8_chk chk4  (.clk(clk), .rst_n(rst_n), .grant(g[1]), .grant_valid(gv[1]));
    rr_arbiter8_chk chk0  (.clk(clk), .rst_n(rst_n), .grant(g[2]), .grant_valid(gv[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner as an integer (-1 = nobody), cycles held so far.
    int m_owner [3];
    int m_held  [3];
    int m_ptr   [3];
    bit m_to    [3];
    int lim     [3] = '{15, 4, 0};

    function automatic int pick(input logic [7:0] m, input int s);
        for (int k = 0; k < 8; k++) begin
            if (m[(s + k) % 8]) return (s + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_grant(input int c);
        logic [7:0] one;
        one = 8'd1;
        return (m_owner[c] < 0) ? 8'd0 : (one << m_owner[c]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_owner[c] = -1; m_held[c] = 0; m_ptr[c] = 0; m_to[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            m_to[c] = 1'b0;
            if (m_owner[c] < 0) begin
                m_owner[c] = pick(req, m_ptr[c]);
                m_held[c]  = 1;
            end else begin
                bit keep, exp;
                keep = req[m_owner[c]];
                exp  = keep && (lim[c] != 0) && (m_held[c] >= lim[c]);
                if (keep && !exp) begin
                    m_held[c]++;
                end else begin
                    m_ptr[c]   = (m_owner[c] + 1) % 8;
                    m_to[c]    = exp;
                    m_owner[c] = pick(req, m_ptr[c]);
                    m_held[c]  = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock: model consumes the current req, then sample #1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [7:0] grant;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int errs;
        logic [31:0] r;
        logic [7:0]  one;
        one = 8'd1;

        rst_n = 1'b0;
        req   = 8'h00;
        #2;
        chk("reset_grant", g[0], 8'h00);
        chk("reset_valid", gv[0], 1'b0);
        chk("reset_timeout", to[0], 1'b0);

        // Table for MAX_HOLD=15: release without dead cycle, wrap 7->0->1, idle, pointer use.
        vecs[0]  = '{8'h05, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{8'h05, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{8'h04, 8'h04, 1'b1, 1'b0};
        vecs[3]  = '{8'h84, 8'h04, 1'b1, 1'b0};
        vecs[4]  = '{8'h80, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{8'h82, 8'h80, 1'b1, 1'b0};
        vecs[6]  = '{8'h02, 8'h02, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'h18, 8'h08, 1'b1, 1'b0};
        vecs[10] = '{8'h10, 8'h10, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d_grant", i), g[0], vecs[i].grant);
            chk($sformatf("vec%0d_valid", i), gv[0], vecs[i].valid);
            chk($sformatf("vec%0d_timeout", i), to[0], vecs[i].tmo);
        end

        // MAX_HOLD=4, all requesting: each owner exactly 4 cycles, timeout on each hand-over.
        do_reset();
        req = 8'hFF;
        for (int k = 1; k <= 37; k++) begin
            tick();
            chk($sformatf("rot%0d_grant", k), g[1], one << (((k - 1) / 4) % 8));
            chk($sformatf("rot%0d_timeout", k), to[1], (k > 1) && ((k - 1) % 4 == 0));
        end

        // MAX_HOLD=4, single requester 5: re-granted, never zero, timeout every 4.
        do_reset();
        req = 8'h20;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sole%0d_grant", k), g[1], 8'h20);
            chk($sformatf("sole%0d_timeout", k), to[1], (k > 1) && ((k - 1) % 4 == 0));
        end

        // MAX_HOLD=0: requester 3 held 300 cycles, no rotation, no timeout.
        do_reset();
        req  = 8'h08;
        errs = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (g[2] !== 8'h08 || to[2] !== 1'b0) errs++;
        end
        chk("nolimit_bad_cycles", errs, 0);
        chk("nolimit_grant_end", g[2], 8'h08);

        // Asynchronous reset in the middle of a grant and during a timeout pulse.
        do_reset();
        req = 8'h10;
        for (int k = 1; k <= 5; k++) tick();
        chk("pre_areset_grant15", g[0], 8'h10);
        chk("pre_areset_timeout4", to[1], 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_grant15", g[0], 8'h00);
        chk("areset_grant4", g[1], 8'h00);
        chk("areset_timeout4", to[1], 1'b0);
        chk("areset_valid15", gv[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        chk("post_areset_grant15", g[0], 8'h01);
        chk("post_areset_grant4", g[1], 8'h01);

        // Randomised traffic on all three instances against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            r = $urandom();
            if (r[31:30] != 2'b00) begin
                req = (r[29]) ? (r[7:0] & r[15:8]) : r[7:0];
            end
            if (r[28:26] == 3'b000) req = 8'h00;
            tick();
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("rnd%0d_c%0d_grant", k, c), g[c], exp_grant(c));
                chk($sformatf("rnd%0d_c%0d_valid", k, c), gv[c], m_owner[c] >= 0);
                chk($sformatf("rnd%0d_c%0d_timeout", k, c), to[c], m_to[c]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
